uart_rx_pkt_ctrl: RTL
=====================

# uart_rx_pkt_ctrl

Packet-level controller placed directly behind the UART receiver. It consumes the receiver's one-cycle byte strobes (`re`/`error`/`datao`) and hunts for framed packets of the form SYNC, LEN, payload, CHK. It validates and buffers each payload, then replays it to the downstream consumer over a valid/ready byte stream. It keeps saturating status counters for link health.

## Interface
- `SYNC_BYTE`, 8'hA5: packet start marker.
- `MAX_LEN`, 16: maximum payload bytes; also the buffer depth (2..255).
- `TIMEOUT_WIDTH`, 16: width of the inter-byte timeout setting.

- `clk`  in  1  system clock.
- `resetb`  in  1  asynchronous, active-low reset.
- `enable`  in  1  0 forces HUNT and ignores rx strobes; counters hold.
- `timeout`  in  TIMEOUT_WIDTH  max clocks between bytes inside a packet; 0 disables.
- `clear_cnt`  in  1  synchronous clear of all counters; wins over increment.
- `rx_re`  in  1  one-cycle strobe: `rx_data` is a good byte.
- `rx_error`  in  1  one-cycle strobe: framing/parity error on received byte.
- `rx_data`  in  8  received byte.
- `out_valid`  out  1  payload byte available.
- `out_ready`  in  1  consumer accepts byte when high with `out_valid`.
- `out_data`  out  8  payload byte.
- `out_last`  out  1  marks final payload byte.
- `good_cnt`, `chk_err_cnt`, `frame_err_cnt`, `drop_cnt`  out  8 each  saturating status counters.

## Operation
- States: HUNT, LEN, DATA, CHK, DRAIN.
- HUNT: `rx_re` with `rx_data`==SYNC_BYTE moves to LEN; all other bytes are discarded.
- LEN:
  - Byte L with 1<=L<=MAX_LEN: store L, seed the running XOR with L, zero the write index, go to DATA.
  - L==0 or L>MAX_LEN: `frame_err_cnt`++ and go to HUNT.
- DATA: each byte is written to `buf[idx]`, XORed into the running checksum, and increments idx. The byte that makes idx==L goes to CHK.
- CHK: byte equals the running XOR → `good_cnt`++ and go to DRAIN with read index 0. Otherwise `chk_err_cnt`++ and go to HUNT.
- DRAIN: present `buf[rd]`; `out_last` = (rd==L-1). Each valid&ready handshake increments rd; the handshake on the last byte returns to HUNT.
- DRAIN overrun: any `rx_re` during DRAIN is dropped and `drop_cnt`++. No hunting during DRAIN.
- `rx_error` in LEN/DATA/CHK: `frame_err_cnt`++ and go to HUNT. `rx_error` in HUNT/DRAIN: `frame_err_cnt`++ only.
- Timeout:
  - Idle counter clears on every `rx_re`/`rx_error` and on entry to LEN.
  - It increments each clock in LEN/DATA/CHK.
  - Reaching `timeout` (nonzero): `frame_err_cnt`++ and go to HUNT. It is idle in HUNT/DRAIN.
- `enable` low:
  - Immediate HUNT from any state, including DRAIN. `out_valid` drops next cycle and the packet is lost.
  - Strobes are ignored.
- Simultaneous `rx_re` and `rx_error`: treat as error.
- Counters saturate at 8'hFF.
- Checksum is 8-bit XOR of LEN and all payload bytes.

## Timing
- Reset values:
  - State HUNT.
  - `out_valid`, `out_last`, `out_data` = 0.
  - All counters 0, indices 0, timeout counter 0.
- Strobe handling: state and counter updates occur on the clock edge where the strobe is sampled high.
- `out_valid` rises on the first cycle in DRAIN, i.e. one clock after the CHK byte strobe.
- Back-to-back acceptance of one byte per clock while `out_ready` is held high; a packet of L bytes drains in L clocks minimum.
- `out_valid`/`out_data`/`out_last` are stable while `out_valid` && !`out_ready`.
- Counter outputs are registered and reflect an event one clock after it.
- Timeout fires exactly `timeout` clocks after the last strobe (or LEN entry).

## Structure
- Shared package `uart_pkg`: state enum, `SYNC_BYTE` default, counter-width constant, saturating-increment function.
- One natural sub-module: `uart_sat_cnt` (8-bit saturating counter with clear/inc), instantiated four times.
- Payload buffer: inferred register array of MAX_LEN×8.

## Test plan
- SYNC_BYTE A5, 03, 11, 22, 33, CHK 03^11^22^33=0x03; `out_ready`=1 → bytes 11, 22, 33 with `out_last` on 33; `good_cnt`=1.
- Same packet with CHK 0x04 → no `out_valid`; `chk_err_cnt`=1; a following good packet is delivered.
- A5, LEN 0x00 and A5, LEN 0x11 (MAX_LEN=16) → `frame_err_cnt`=2, no output. `rx_error` mid-DATA → `frame_err_cnt`+1, state HUNT.
- `timeout`=50; A5, 02, 7E, then silence → HUNT at 50 clocks; `frame_err_cnt`=1. With `timeout`=0 there is no abort.
- Good 2-byte packet with `out_ready`=0 for 20 clocks while 3 bytes arrive → `drop_cnt`=3, held output stable. Then ready → both bytes delivered.
- 300 bad-LEN packets → `frame_err_cnt` saturates at FF; pulse `clear_cnt` together with an error → 0. Reset mid-DRAIN → `out_valid`=0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, constants and helpers for the UART packet controller
package uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_DRAIN
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CNT_W         = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_sat_cnt.sv
// rtl/uart_sat_cnt.sv - saturating status counter with synchronous clear
module uart_sat_cnt
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             resetb,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Clear takes priority so a clear coinciding with an event still yields zero.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - hunts SYNC/LEN/payload/CHK packets from the UART receiver and replays payloads
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     enable,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  input  logic                     clear_cnt,
  input  logic                     rx_re,
  input  logic                     rx_error,
  input  logic [7:0]               rx_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_last,
  output logic [CNT_W-1:0]         good_cnt,
  output logic [CNT_W-1:0]         chk_err_cnt,
  output logic [CNT_W-1:0]         frame_err_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int                       IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]               MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE   = TIMEOUT_WIDTH'(1);

  state_e                   state_q, state_d;
  logic [7:0]               len_q, len_d;
  logic [7:0]               chk_q, chk_d;
  logic [7:0]               idx_q, idx_d;
  logic [7:0]               rd_q, rd_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [7:0]               buf_q [MAX_LEN];

  logic buf_we, inc_good, inc_chk, inc_frame, inc_drop;
  logic err, re, tmo_hit, hs;
  logic [7:0] idx_inc;

  // Error wins over a simultaneous good-byte strobe; both are ignored while disabled.
  assign err     = enable && rx_error;
  assign re      = enable && rx_re && !rx_error;
  assign tmo_hit = (timeout != '0) && ((tmo_q + TMO_ONE) == timeout);
  assign idx_inc = idx_q + 8'd1;

  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = out_valid ? buf_q[rd_q[IDX_W-1:0]] : 8'h00;
  assign out_last  = out_valid && (rd_q == (len_q - 8'd1));
  assign hs        = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    rd_d      = rd_q;
    tmo_d     = '0;
    buf_we    = 1'b0;
    inc_good  = 1'b0;
    inc_chk   = 1'b0;
    inc_frame = 1'b0;
    inc_drop  = 1'b0;
    if (!enable) begin
      state_d = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (err) begin
            inc_frame = 1'b1;
          end else if (re && (rx_data == SYNC_BYTE)) begin
            state_d = ST_LEN;
          end
        end
        ST_LEN, ST_DATA, ST_CHK: begin
          if (err) begin
            inc_frame = 1'b1;
            state_d   = ST_HUNT;
          end else if (re) begin
            case (state_q)
              ST_LEN: begin
                if ((rx_data != 8'h00) && (rx_data <= MAX_LEN_B)) begin
                  len_d   = rx_data;
                  chk_d   = rx_data;
                  idx_d   = 8'h00;
                  state_d = ST_DATA;
                end else begin
                  inc_frame = 1'b1;
                  state_d   = ST_HUNT;
                end
              end
              ST_DATA: begin
                buf_we = 1'b1;
                chk_d  = chk_q ^ rx_data;
                idx_d  = idx_inc;
                if (idx_inc == len_q) begin
                  state_d = ST_CHK;
                end
              end
              default: begin
                if (rx_data == chk_q) begin
                  inc_good = 1'b1;
                  rd_d     = 8'h00;
                  state_d  = ST_DRAIN;
                end else begin
                  inc_chk = 1'b1;
                  state_d = ST_HUNT;
                end
              end
            endcase
          end else if (tmo_hit) begin
            inc_frame = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
          end
        end
        ST_DRAIN: begin
          inc_frame = err;
          inc_drop  = re;
          if (hs) begin
            rd_d = rd_q + 8'd1;
            if (out_last) begin
              state_d = ST_HUNT;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_HUNT;
      len_q   <= 8'h00;
      chk_q   <= 8'h00;
      idx_q   <= 8'h00;
      rd_q    <= 8'h00;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[idx_q[IDX_W-1:0]] <= rx_data;
    end
  end

  uart_sat_cnt u_good_cnt (
    .clk(clk), .resetb(resetb), .clr_i(clear_cnt), .inc_i(inc_good), .cnt_o(good_cnt)
  );
  uart_sat_cnt u_chk_err_cnt (
    .clk(clk), .resetb(resetb), .clr_i(clear_cnt), .inc_i(inc_chk), .cnt_o(chk_err_cnt)
  );
  uart_sat_cnt u_frame_err_cnt (
    .clk(clk), .resetb(resetb), .clr_i(clear_cnt), .inc_i(inc_frame), .cnt_o(frame_err_cnt)
  );
  uart_sat_cnt u_drop_cnt (
    .clk(clk), .resetb(resetb), .clr_i(clear_cnt), .inc_i(inc_drop), .cnt_o(drop_cnt)
  );

endmodule
